// File: rtl/l2todr_req_tracker.sv
//------------------------------------------------------------------------------
// l2todr_req_tracker : forwards L2 requests/snacks, tracks outstanding nids
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

// Two-entry registered skid FIFO: retry depends only on local occupancy.
module l2todr_req_tracker_fflop #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_retry,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_retry,
  output logic [W-1:0] o_data
);
  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_full;
  logic         w_wr;
  logic         w_rd;

  assign w_full  = (r_count == 2'd2);
  assign o_retry = w_full;
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];
  assign w_wr    = i_valid & ~w_full;
  assign w_rd    = o_valid & ~i_retry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_rd) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_wr} - {1'b0, w_rd};
    end
  end
endmodule

// Payloads are opaque except for nid, which sits in the low NID_BITS bits.
module l2todr_req_tracker #(
  parameter int NID_BITS = 5,
  parameter int MAX_OUT  = 16,
  parameter int TIMEOUT  = 1024,
  parameter int REQ_W    = 64,
  parameter int SNACK_W  = 64,
  parameter int CNT_W    = $clog2(MAX_OUT + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_req_valid,
  output logic               in_req_retry,
  input  logic [REQ_W-1:0]   in_req,
  output logic               l2todr_req_valid,
  input  logic               l2todr_req_retry,
  output logic [REQ_W-1:0]   l2todr_req,
  input  logic               drtol2_snack_valid,
  output logic               drtol2_snack_retry,
  input  logic [SNACK_W-1:0] drtol2_snack,
  output logic               out_snack_valid,
  input  logic               out_snack_retry,
  output logic [SNACK_W-1:0] out_snack,
  output logic [CNT_W-1:0]   outstanding_cnt,
  output logic               err_timeout
);
  localparam int                    c_NUM_ENT = 2 ** NID_BITS;
  localparam int                    c_WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [c_WD_W-1:0]     c_TIMEOUT = c_WD_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]      c_MAX_OUT = CNT_W'(MAX_OUT);

  logic [c_NUM_ENT-1:0] r_busy;
  logic [CNT_W-1:0]     r_count;
  logic [c_WD_W-1:0]    r_wd;
  logic                 r_err;

  logic [NID_BITS-1:0]  w_req_nid;
  logic [NID_BITS-1:0]  w_snk_nid;
  logic                 w_reqf_full;
  logic                 w_snkf_full;
  logic                 w_req_acc;
  logic                 w_snk_acc;
  logic                 w_retire;

  assign w_req_nid = in_req[NID_BITS-1:0];
  assign w_snk_nid = drtol2_snack[NID_BITS-1:0];

  // Table state is the start-of-cycle value, so a nid freed this cycle is retried once.
  assign in_req_retry       = w_reqf_full | r_busy[w_req_nid] | (r_count == c_MAX_OUT);
  assign w_req_acc          = in_req_valid & ~in_req_retry;
  assign drtol2_snack_retry = w_snkf_full;
  assign w_snk_acc          = drtol2_snack_valid & ~w_snkf_full;
  assign w_retire           = w_snk_acc & r_busy[w_snk_nid];

  assign outstanding_cnt = r_count;
  assign err_timeout     = r_err;

  l2todr_req_tracker_fflop #(.W(REQ_W)) u_req_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_valid (w_req_acc),
    .o_retry (w_reqf_full),
    .i_data  (in_req),
    .o_valid (l2todr_req_valid),
    .i_retry (l2todr_req_retry),
    .o_data  (l2todr_req)
  );

  l2todr_req_tracker_fflop #(.W(SNACK_W)) u_snk_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_valid (w_snk_acc),
    .o_retry (w_snkf_full),
    .i_data  (drtol2_snack),
    .o_valid (out_snack_valid),
    .i_retry (out_snack_retry),
    .o_data  (out_snack)
  );

  // An accepted request needs busy=0 and a retire needs busy=1, so the nids never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      if (w_retire)  r_busy[w_snk_nid] <= 1'b0;
      if (w_req_acc) r_busy[w_req_nid] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      unique case ({w_req_acc, w_retire})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else if (w_retire || (r_count == '0)) begin
      r_wd <= '0;
    end else if (r_wd != c_TIMEOUT) begin
      r_wd <= r_wd + c_WD_W'(1);
      if ((r_wd + c_WD_W'(1)) == c_TIMEOUT) r_err <= 1'b1;
    end
  end
endmodule

`default_nettype wire
